div_unit: RTL

//  Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU ops. It is the multi-cycle counterpart of the single-cycle ALU.
//  The execute stage issues an operand pair and op over a valid/ready request port.
//  The result returns later over a valid/ready response port.

---
 rtl/div_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per enabled cycle; sign fix-up when the result is loaded.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clk_en_i,
  input  logic            kill_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] req_left_i,
  input  logic [XLEN-1:0] req_right_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_result_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_rem_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   dsr_q;

  logic              sgn_op;
  logic              l_neg;
  logic              r_neg;
  logic [XLEN-1:0]   l_mag;
  logic [XLEN-1:0]   r_mag;
  logic              div_zero;
  logic              ovf;
  logic [XLEN-1:0]   spec_res;
  logic [XLEN:0]     sh;
  logic [XLEN:0]     diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quo_nx;
  logic [XLEN-1:0]   fin_res;

  assign req_ready_o = (state_q == IDLE);

  always_comb begin
    sgn_op   = ~req_op_i[0];
    l_neg    = sgn_op & req_left_i[XLEN-1];
    r_neg    = sgn_op & req_right_i[XLEN-1];
    l_mag    = l_neg ? ('0 - req_left_i) : req_left_i;
    r_mag    = r_neg ? ('0 - req_right_i) : req_right_i;
    div_zero = (req_right_i == '0);
    ovf      = sgn_op && (req_left_i == MIN_NEG)
             && (req_right_i == '1);
    spec_res = '0;
    unique case (1'b1)
      div_zero && req_op_i[1]:  spec_res = req_left_i;
      div_zero && !req_op_i[1]: spec_res = '1;
      !div_zero && req_op_i[1]: spec_res = '0;
      default:                  spec_res = MIN_NEG;
    endcase
  end

  // Working remainder is one bit wider so the shifted value never overflows
  always_comb begin
    sh     = {rem_q, quo_q[XLEN-1]};
    diff   = sh - {1'b0, dsr_q};
    ge     = ~diff[XLEN];
    rem_nx = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ge};
    if (is_rem_q)
      fin_res = neg_r_q ? ('0 - rem_nx) : rem_nx;
    else
      fin_res = neg_q_q ? ('0 - quo_nx) : quo_nx;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_rem_q     <= 1'b0;
      neg_q_q      <= 1'b0;
      neg_r_q      <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      dsr_q        <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
    end else if (clk_en_i) begin
      if (kill_i) begin
        state_q     <= IDLE;
        rsp_valid_o <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (req_valid_i) begin
              is_rem_q <= req_op_i[1];
              neg_q_q  <= l_neg ^ r_neg;
              neg_r_q  <= l_neg;
              rem_q    <= '0;
              quo_q    <= l_mag;
              dsr_q    <= r_mag;
              if (div_zero || ovf) begin
                state_q      <= DONE;
                rsp_valid_o  <= 1'b1;
                rsp_result_o <= spec_res;
              end else begin
                state_q <= BUSY;
                cnt_q   <= CNT_W'(XLEN-1);
              end
            end
          end
          BUSY: begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (cnt_q == '0) begin
              state_q      <= DONE;
              rsp_valid_o  <= 1'b1;
              rsp_result_o <= fin_res;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          DONE: begin
            if (rsp_ready_i) begin
              state_q     <= IDLE;
              rsp_valid_o <= 1'b0;
            end
          end
          default: begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
